// File: rtl/noc_router_p.sv
// noc_router_p: five-port single-flit NoC router with per-input FIFOs, XY routing and round-robin output arbiters.
// Port index order everywhere: N=0, S=1, E=2, W=3, L=4.
module noc_router_p #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 3,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] n_i,
  input  logic              n_vld_i,
  output logic              n_rdy_o,
  output logic [DATA_W-1:0] n_o,
  output logic              n_vld_o,
  input  logic              n_rdy_i,
  input  logic [DATA_W-1:0] s_i,
  input  logic              s_vld_i,
  output logic              s_rdy_o,
  output logic [DATA_W-1:0] s_o,
  output logic              s_vld_o,
  input  logic              s_rdy_i,
  input  logic [DATA_W-1:0] e_i,
  input  logic              e_vld_i,
  output logic              e_rdy_o,
  output logic [DATA_W-1:0] e_o,
  output logic              e_vld_o,
  input  logic              e_rdy_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic              w_vld_i,
  output logic              w_rdy_o,
  output logic [DATA_W-1:0] w_o,
  output logic              w_vld_o,
  input  logic              w_rdy_i,
  input  logic [DATA_W-1:0] l_i,
  input  logic              l_vld_i,
  output logic              l_rdy_o,
  output logic [DATA_W-1:0] l_o,
  output logic              l_vld_o,
  input  logic              l_rdy_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [COORD_W-1:0] XC = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y_ID);

  logic [DATA_W-1:0] din [5];
  logic [4:0]        vld_i, rdy_i, rdy_o, push, pop, free, gv;
  logic [DATA_W-1:0] mem_q [5][DEPTH];
  logic [AW-1:0]     rd_q [5], wr_q [5];
  logic [CW-1:0]     cnt_q [5];
  logic [DATA_W-1:0] out_q [5];
  logic [4:0]        ovld_q;
  logic [2:0]        ptr_q [5];
  logic [DATA_W-1:0] head [5];
  logic [2:0]        route [5], gi [5];
  logic [4:0]        req [5];

  function automatic logic [2:0] route_of(input logic [DATA_W-1:0] f);
    logic [COORD_W-1:0] dx, dy;
    dx = f[DATA_W-1 -: COORD_W];
    dy = f[DATA_W-1-COORD_W -: COORD_W];
    return dx > XC ? 3'd2 : dx < XC ? 3'd3 : dy > YC ? 3'd0 : dy < YC ? 3'd1 : 3'd4;
  endfunction

  // Returns {found, index}; scanning downward lets the requester nearest ptr win.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] ptr);
    logic [3:0] res, s;
    res = '0;
    for (int k = 4; k >= 0; k--) begin
      s   = {1'b0, ptr} + 4'(k);
      s   = s >= 4'd5 ? s - 4'd5 : s;
      res = r[s[2:0]] ? {1'b1, s[2:0]} : res;
    end
    return res;
  endfunction

  assign din[0] = n_i;
  assign din[1] = s_i;
  assign din[2] = e_i;
  assign din[3] = w_i;
  assign din[4] = l_i;
  assign vld_i = {l_vld_i, w_vld_i, e_vld_i, s_vld_i, n_vld_i};
  assign rdy_i = {l_rdy_i, w_rdy_i, e_rdy_i, s_rdy_i, n_rdy_i};
  assign {l_rdy_o, w_rdy_o, e_rdy_o, s_rdy_o, n_rdy_o} = rdy_o;
  assign {l_vld_o, w_vld_o, e_vld_o, s_vld_o, n_vld_o} = ovld_q;
  assign n_o = out_q[0];
  assign s_o = out_q[1];
  assign e_o = out_q[2];
  assign w_o = out_q[3];
  assign l_o = out_q[4];

  for (genvar g = 0; g < 5; g++) begin : g_port
    assign rdy_o[g] = cnt_q[g] != CW'(DEPTH);
    assign push[g]  = vld_i[g] && rdy_o[g];
    assign head[g]  = mem_q[g][rd_q[g]];
    assign route[g] = route_of(head[g]);
    assign free[g]  = !ovld_q[g] || rdy_i[g];
    assign {gv[g], gi[g]} = free[g] ? rr_pick(req[g], ptr_q[g]) : 4'd0;
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int i = 0; i < 5; i++) begin
        req[o][i] = (cnt_q[i] != '0) && (route[i] == 3'(o));
        pop[i]    = pop[i] | (gv[o] && gi[o] == 3'(i));
      end
    end
  end

  always_ff @(posedge clk)
    for (int i = 0; i < 5; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= din[i];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovld_q <= '0;
      for (int i = 0; i < 5; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
        out_q[i] <= '0;
        ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        wr_q[i]   <= wr_q[i] + AW'(push[i]);
        rd_q[i]   <= rd_q[i] + AW'(pop[i]);
        cnt_q[i]  <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        ovld_q[i] <= gv[i] | (ovld_q[i] & ~rdy_i[i]);
        out_q[i]  <= gv[i] ? head[gi[i]] : out_q[i];
        ptr_q[i]  <= gv[i] ? (gi[i] == 3'd4 ? 3'd0 : gi[i] + 3'd1) : ptr_q[i];
      end
    end
endmodule

// File: tb/tb_noc_router_p.sv
// tb_noc_router_p: directed and random checks of noc_router_p at node (1,1) against a per-(source,output) queue model.
module tb_noc_router_p;
  logic        clk = 0, rst = 1;
  logic [15:0] din [5];
  logic [4:0]  vin, rdy_i;
  wire  [15:0] dout [5];
  wire  [4:0]  rdy_o, vout;
  int          total = 0, bad = 0, acc_cnt = 0;
  logic [15:0] sb [5][5][$];
  logic [4:0]  stall_prev;
  logic [15:0] prev_d [5];
  logic [15:0] f [8], g [8];

  always #5 clk = ~clk;

  noc_router_p #(.DATA_W(16), .DEPTH(4), .COORD_W(3), .X_ID(1), .Y_ID(1)) dut (
    .clk(clk), .rst(rst),
    .n_i(din[0]), .n_vld_i(vin[0]), .n_rdy_o(rdy_o[0]), .n_o(dout[0]), .n_vld_o(vout[0]), .n_rdy_i(rdy_i[0]),
    .s_i(din[1]), .s_vld_i(vin[1]), .s_rdy_o(rdy_o[1]), .s_o(dout[1]), .s_vld_o(vout[1]), .s_rdy_i(rdy_i[1]),
    .e_i(din[2]), .e_vld_i(vin[2]), .e_rdy_o(rdy_o[2]), .e_o(dout[2]), .e_vld_o(vout[2]), .e_rdy_i(rdy_i[2]),
    .w_i(din[3]), .w_vld_i(vin[3]), .w_rdy_o(rdy_o[3]), .w_o(dout[3]), .w_vld_o(vout[3]), .w_rdy_i(rdy_i[3]),
    .l_i(din[4]), .l_vld_i(vin[4]), .l_rdy_o(rdy_o[4]), .l_o(dout[4]), .l_vld_o(vout[4]), .l_rdy_i(rdy_i[4])
  );

  function automatic logic [15:0] mk(int dx, int dy, int s, int q);
    return {3'(dx), 3'(dy), 3'(s), 7'(q)};
  endfunction

  // Dimension-order routing for a node at (1,1): X first, then Y.
  function automatic int rt(logic [15:0] fl);
    int dx, dy;
    dx = int'(fl[15:13]);
    dy = int'(fl[12:10]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++)
      for (int o = 0; o < 5; o++) sb[i][o].delete();
    stall_prev = '0;
  endtask

  // Records transfers at the negedge before each edge, then returns just after the edge.
  task automatic tick();
    int src, ok;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      if (vin[i] && rdy_o[i]) begin
        sb[i][rt(din[i])].push_back(din[i]);
        acc_cnt++;
      end
    for (int o = 0; o < 5; o++) begin
      if (stall_prev[o]) begin
        chk($sformatf("stall_vld%0d", o), 32'(vout[o]), 32'd1);
        chk($sformatf("stall_data%0d", o), 32'(dout[o]), 32'(prev_d[o]));
      end
      if (vout[o] && rdy_i[o]) begin
        src = int'(dout[o][9:7]);
        ok = 0;
        if (src <= 4) ok = sb[src][o].size() > 0 ? 1 : 0;
        chk($sformatf("pending_out%0d", o), 32'(ok), 32'd1);
        chk($sformatf("route_out%0d", o), 32'(rt(dout[o])), 32'(o));
        if (ok == 1) chk($sformatf("order_out%0d", o), 32'(dout[o]), 32'(sb[src][o].pop_front()));
      end
      stall_prev[o] = vout[o] && !rdy_i[o];
      prev_d[o] = dout[o];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dxs [4] = '{1, 1, 0, 1};
    int dys [4] = '{3, 0, 2, 1};
    int exo [4] = '{0, 1, 3, 4};
    int guard, left;
    logic [15:0] fl;
    vin = '0;
    rdy_i = '1;
    for (int i = 0; i < 5; i++) din[i] = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_vld", 32'(vout), 32'h0);
    chk("rst_rdy", 32'(rdy_o), 32'h1f);
    for (int o = 0; o < 5; o++) chk($sformatf("rst_data%0d", o), 32'(dout[o]), 32'h0);

    // Two-cycle latency L -> E, then the other route directions.
    fl = mk(3, 0, 4, 1);
    vin[4] = 1; din[4] = fl;
    tick();
    vin[4] = 0;
    chk("lat_not_yet", 32'(vout[2]), 32'd0);
    tick();
    chk("lat_vld", 32'(vout[2]), 32'd1);
    chk("lat_data", 32'(dout[2]), 32'(fl));
    for (int c = 0; c < 4; c++) begin
      fl = mk(dxs[c], dys[c], 4, 2 + c);
      vin[4] = 1; din[4] = fl;
      tick();
      vin[4] = 0;
      tick();
      chk($sformatf("route_vld%0d", c), 32'(vout[exo[c]]), 32'd1);
      chk($sformatf("route_data%0d", c), 32'(dout[exo[c]]), 32'(fl));
      tick();
    end

    // Contention on L output: ptr is 0, so N, S, W, L in index order.
    for (int i = 0; i < 5; i++) f[i] = mk(1, 1, i, 10 + i);
    vin = 5'b11011;
    for (int i = 0; i < 5; i++) din[i] = f[i];
    tick();
    vin = '0;
    foreach (exo[k]) begin
      tick();
      chk($sformatf("rr_data%0d", k), 32'(dout[4]), 32'(f[k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 3 : 4]));
    end
    // ptr wrapped to 0 after L, so N precedes L.
    f[0] = mk(1, 1, 0, 15); f[4] = mk(1, 1, 4, 16);
    vin = 5'b10001; din[0] = f[0]; din[4] = f[4];
    tick();
    vin = '0;
    tick();
    chk("rr_wrap_first", 32'(dout[4]), 32'(f[0]));
    tick();
    chk("rr_wrap_second", 32'(dout[4]), 32'(f[4]));
    tick();

    // Backpressure: 4 FIFO entries plus the output register.
    rdy_i[2] = 0;
    for (int k = 0; k < 6; k++) begin
      f[k] = mk(3, 1, 3, 20 + k);
      chk($sformatf("bp_rdy%0d", k), 32'(rdy_o[3]), 32'(k < 5));
      vin[3] = 1; din[3] = f[k];
      tick();
    end
    vin[3] = 0;
    tick();
    chk("bp_hold_vld", 32'(vout[2]), 32'd1);
    chk("bp_hold_data", 32'(dout[2]), 32'(f[0]));
    chk("bp_still_full", 32'(rdy_o[3]), 32'd0);
    rdy_i[2] = 1;
    tick();
    chk("bp_rdy_back", 32'(rdy_o[3]), 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("bp_drain%0d", k), 32'(dout[2]), 32'(f[k]));
      tick();
    end
    chk("bp_empty", 32'(vout[2]), 32'd0);

    // Parallel N->S and E->W streams.
    for (int k = 0; k < 8; k++) begin
      f[k] = mk(1, 0, 0, 40 + k);
      g[k] = mk(0, 1, 2, 60 + k);
    end
    for (int c = 0; c <= 8; c++) begin
      vin[0] = c < 8; vin[2] = c < 8;
      din[0] = f[c % 8]; din[2] = g[c % 8];
      tick();
      if (c >= 1) begin
        chk($sformatf("par_s%0d", c), {15'd0, vout[1], dout[1]}, {16'd1, f[c - 1]});
        chk($sformatf("par_w%0d", c), {15'd0, vout[3], dout[3]}, {16'd1, g[c - 1]});
      end
    end
    vin = '0;
    tick();

    // Random traffic with a toggling e_rdy_i; scoreboard checks every emission.
    acc_cnt = 0;
    guard = 0;
    while (acc_cnt < 200 && guard < 5000) begin
      for (int i = 0; i < 5; i++) begin
        vin[i] = 1'($urandom_range(1));
        din[i] = mk($urandom_range(7), $urandom_range(7), i, guard);
        rdy_i[i] = i == 2 ? 1'($urandom_range(1)) : ($urandom_range(3) != 0);
      end
      tick();
      guard++;
    end
    chk("rand_budget", 32'(guard < 5000), 32'd1);
    vin = '0;
    rdy_i = '1;
    repeat (40) tick();
    left = 0;
    for (int i = 0; i < 5; i++)
      for (int o = 0; o < 5; o++) left += sb[i][o].size();
    chk("rand_all_delivered", 32'(left), 32'd0);

    // Asynchronous reset in the middle of stalled traffic.
    rdy_i = '0;
    vin = 5'b10101;
    din[0] = mk(1, 3, 0, 90); din[2] = mk(0, 0, 2, 91); din[4] = mk(3, 3, 4, 92);
    repeat (3) tick();
    vin = '0;
    chk("pre_rst_busy", 32'(vout != 0), 32'd1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_vld", 32'(vout), 32'h0);
    chk("async_rdy", 32'(rdy_o), 32'h1f);
    chk("async_data_e", 32'(dout[2]), 32'h0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rdy_i = '1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", k), 32'(vout), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
